// File: rtl/cam_alloc_pkg.sv
// rtl/cam_alloc_pkg.sv - shared types for the CAM entry allocator
package cam_alloc_pkg;
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } alloc_state_e;
endpackage

// File: rtl/cam_alloc_pick.sv
// rtl/cam_alloc_pick.sv - combinational first-zero finder, lowest or highest index first
`include "parammod_stddef.vh"
module cam_alloc_pick #(
   parameter int DEPTH = 64,
   parameter bit MSB   = `FALSE,
   parameter int ADDR  = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] valid_i,
   output logic             found_o,
   output logic [ADDR-1:0]  index_o
);
   // The scan order is chosen so the preferred zero is the last one written.
   always_comb begin
      found_o = 1'b0;
      index_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (MSB == `TRUE) begin
            if (!valid_i[i]) begin
               found_o = 1'b1;
               index_o = ADDR'(i);
            end
         end else begin
            if (!valid_i[DEPTH-1-i]) begin
               found_o = 1'b1;
               index_o = ADDR'(DEPTH-1-i);
            end
         end
      end
   end
endmodule

// File: rtl/parammod_stddef.vh
// rtl/parammod_stddef.vh - shared boolean and enable literals
`ifndef PARAMMOD_STDDEF_VH
`define PARAMMOD_STDDEF_VH
`define TRUE    1'b1
`define FALSE   1'b0
`define ENABLE  1'b1
`define DISABLE 1'b0
`endif

// File: rtl/cam_alloc.sv
// rtl/cam_alloc.sv - CAM write-side entry allocator; optional err output under CAM_ALLOC_CHECK_EN
`include "parammod_stddef.vh"
module cam_alloc
   import cam_alloc_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int FREE  = 2,
   parameter bit MSB   = `FALSE,
   parameter int ADDR  = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc_req,
   output logic                 alloc_valid,
   input  logic                 alloc_ready,
   output logic [ADDR-1:0]      alloc_addr,
   output logic                 alloc_evict,
   input  logic [FREE-1:0]      free_en,
   input  logic [FREE*ADDR-1:0] free_addr,
   output logic [DEPTH-1:0]     valid,
   output logic                 full,
   output logic [ADDR:0]        count
`ifdef CAM_ALLOC_CHECK_EN
   ,output logic                err
`endif
);
   alloc_state_e     state_q, state_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [ADDR:0]    count_q, count_d;
   logic             full_q, full_d;
   logic [ADDR-1:0]  addr_q, addr_d;
   logic             evict_q, evict_d;
   logic [ADDR-1:0]  victim_q, victim_d;
   logic             pick_found;
   logic [ADDR-1:0]  pick_index;
   logic [ADDR-1:0]  fa;

   cam_alloc_pick #(.DEPTH(DEPTH), .MSB(MSB), .ADDR(ADDR)) u_pick (
      .valid_i (valid_q),
      .found_o (pick_found),
      .index_o (pick_index)
   );

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      addr_d   = addr_q;
      evict_d  = evict_q;
      victim_d = victim_q;
      fa       = '0;
      // Frees first so a reservation on the same index overrides them.
      for (int p = 0; p < FREE; p++) begin
         fa = free_addr[p*ADDR +: ADDR];
         if (free_en[p] && int'(fa) < DEPTH && !(state_q == GRANT && fa == addr_q))
            valid_d[fa] = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (alloc_req) begin
               if (!full_q && pick_found) begin
                  addr_d  = pick_index;
                  evict_d = 1'b0;
               end else begin
                  addr_d  = victim_q;
                  evict_d = 1'b1;
               end
               valid_d[addr_d] = 1'b1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (alloc_ready) begin
               state_d = IDLE;
               if (evict_q)
                  victim_d = (victim_q == ADDR'(DEPTH-1)) ? '0 : victim_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      count_d = '0;
      for (int i = 0; i < DEPTH; i++)
         count_d = count_d + (ADDR+1)'(valid_d[i]);
      full_d = (count_d == (ADDR+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (reset == `ENABLE) begin
         state_q  <= IDLE;
         valid_q  <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         addr_q   <= '0;
         evict_q  <= 1'b0;
         victim_q <= '0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
         full_q   <= full_d;
         addr_q   <= addr_d;
         evict_q  <= evict_d;
         victim_q <= victim_d;
      end
   end

   assign alloc_valid = (state_q == GRANT);
   assign alloc_addr  = addr_q;
   assign alloc_evict = evict_q;
   assign valid       = valid_q;
   assign count       = count_q;
   assign full        = full_q;

`ifdef CAM_ALLOC_CHECK_EN
   logic err_q, err_d;
   logic [ADDR-1:0] ca;

   always_comb begin
      err_d = err_q | (alloc_ready & ~alloc_valid);
      ca    = '0;
      for (int p = 0; p < FREE; p++) begin
         ca = free_addr[p*ADDR +: ADDR];
         if (free_en[p] && int'(ca) < DEPTH) begin
            if (!valid_q[ca] || (state_q == GRANT && ca == addr_q))
               err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset == `ENABLE)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign err = err_q;
`endif
endmodule

// File: tb/tb_cam_alloc.sv
// tb/tb_cam_alloc.sv - scoreboard bench for cam_alloc with DEPTH=4, FREE=2, lowest-index pick
module tb_cam_alloc;
   localparam int DEPTH = 4;
   localparam int FREE  = 2;
   localparam int ADDR  = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 alloc_req;
   logic                 alloc_valid;
   logic                 alloc_ready;
   logic [ADDR-1:0]      alloc_addr;
   logic                 alloc_evict;
   logic [FREE-1:0]      free_en;
   logic [FREE*ADDR-1:0] free_addr;
   logic [DEPTH-1:0]     valid;
   logic                 full;
   logic [ADDR:0]        count;
`ifdef CAM_ALLOC_CHECK_EN
   logic                 err;
`endif

   cam_alloc #(.DEPTH(DEPTH), .FREE(FREE), .MSB(1'b0)) dut (
      .clk         (clk),
      .reset       (reset),
      .alloc_req   (alloc_req),
      .alloc_valid (alloc_valid),
      .alloc_ready (alloc_ready),
      .alloc_addr  (alloc_addr),
      .alloc_evict (alloc_evict),
      .free_en     (free_en),
      .free_addr   (free_addr),
      .valid       (valid),
      .full        (full),
      .count       (count)
`ifdef CAM_ALLOC_CHECK_EN
      ,.err        (err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [2:0]       sb_q[$];
   logic [DEPTH-1:0] m_valid;
   int               m_victim;
   logic             m_gevict;
   logic [ADDR-1:0]  m_gaddr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int popc(input logic [DEPTH-1:0] v);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_valid"}, 32'(valid), 32'(m_valid));
      check({tag, "_count"}, 32'(count), 32'(popc(m_valid)));
      check({tag, "_full"},  32'(full),  32'(m_valid == '1));
   endtask

   task automatic predict(output logic [ADDR-1:0] a, output logic ev);
      a  = '0;
      ev = 1'b0;
      if (m_valid == '1) begin
         a  = ADDR'(m_victim);
         ev = 1'b1;
      end else begin
         for (int i = DEPTH-1; i >= 0; i--)
            if (!m_valid[i]) a = ADDR'(i);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; alloc_req = 1'b0; alloc_ready = 1'b0; free_en = '0; free_addr = '0;
      step(); step();
      reset = 1'b0;
      m_valid = '0; m_victim = 0; m_gevict = 1'b0; m_gaddr = '0;
      sb_q.delete();
      check("rst_alloc_valid", 32'(alloc_valid), 32'd0);
      check("rst_alloc_addr",  32'(alloc_addr),  32'd0);
      check("rst_alloc_evict", 32'(alloc_evict), 32'd0);
      check_state("rst");
   endtask

   // One-cycle request, optionally with a single free on port 0 in the same cycle.
   task automatic request(input logic fe, input logic [ADDR-1:0] fa, input logic hold);
      logic [ADDR-1:0] a;
      logic ev;
      predict(a, ev);
      sb_q.push_back({ev, a});
      alloc_req = 1'b1; free_en = {1'b0, fe}; free_addr = {{ADDR{1'b0}}, fa};
      step();
      alloc_req = hold; free_en = '0;
      if (fe) m_valid[fa] = 1'b0;
      m_valid[a] = 1'b1;
      m_gaddr = a; m_gevict = ev;
      check("grant_valid", 32'(alloc_valid), 32'd1);
   endtask

   task automatic ack();
      logic [2:0] e;
      alloc_req = 1'b0;
      alloc_ready = 1'b1;
      if (!alloc_valid) begin
         check("ack_valid", 32'(alloc_valid), 32'd1);
      end else if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check("grant_addr",  32'(alloc_addr),  32'(e[1:0]));
         check("grant_evict", 32'(alloc_evict), 32'(e[2]));
      end
      step();
      alloc_ready = 1'b0;
      if (m_gevict) m_victim = (m_victim == DEPTH-1) ? 0 : m_victim + 1;
      check("ack_idle", 32'(alloc_valid), 32'd0);
      check_state("ack");
   endtask

   initial begin
      do_reset();

`ifdef CAM_ALLOC_CHECK_EN
      free_en = 2'b01; free_addr = {2'd0, 2'd2};
      step();
      free_en = '0;
      for (int i = 0; i < 3; i++) begin
         check("err_sticky", 32'(err), 32'd1);
         step();
      end
      do_reset();
      check("err_reset", 32'(err), 32'd0);
`endif

      // Fill from empty, then five evictions to exercise the victim wrap.
      for (int i = 0; i < 4; i++) begin request(1'b0, '0, 1'b0); ack(); end
      for (int i = 0; i < 5; i++) begin request(1'b0, '0, 1'b0); ack(); end

      // Grant held with ready low and req still asserted.
      request(1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(alloc_valid), 32'd1);
         check("hold_addr",  32'(alloc_addr),  32'(m_gaddr));
         check("hold_evict", 32'(alloc_evict), 32'(m_gevict));
         check("hold_count", 32'(count),       32'(DEPTH));
         step();
      end
      ack();

      // Two-port free, then refill lowest hole.
      free_en = 2'b11; free_addr = {2'd2, 2'd1};
      step();
      free_en = '0;
      m_valid[2] = 1'b0; m_valid[1] = 1'b0;
      check_state("free2");
      check("free2_bits", 32'(valid), 32'b1001);
      request(1'b0, '0, 1'b0); ack();
      request(1'b0, '0, 1'b0); ack();

      // Full from reset: pick uses the pre-free view, then a free of the held grant is ignored.
      do_reset();
      for (int i = 0; i < 4; i++) begin request(1'b0, '0, 1'b0); ack(); end
      request(1'b1, 2'd3, 1'b0);
      check("same_cycle_bits", 32'(valid), 32'b0111);
      check_state("same_cycle");
      free_en = 2'b01; free_addr = {2'd0, 2'd0};
      step();
      free_en = '0;
      check_state("grant_free");
      ack();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", checks, 0);
      $fatal(1);
   end
endmodule
